ahbl_apb_bridge: RTL and testbench

//  AHB-Lite slave that converts single AHB-Lite transfers into APB3 transfers.
//  It sits downstream of the AHB-Lite master / bus fabric, in the peripheral region (0x40_000000..0x4F_FFFFFF).
//  It decodes one of NUM_SLAVES PSEL lines from the AHB address.
//  It runs one transfer at a time and stalls the AHB data phase with HREADYOUT until the APB slave completes.

---
 rtl/ahbl_apb_bridge.sv | 179 +++++++++++++++++
 tb/tb_ahbl_apb_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahbl_apb_bridge
// AHB-Lite slave that turns single AHB-Lite transfers into APB3 transfers.
// One transfer is in flight at a time; the AHB data phase is stretched with
// HREADYOUT until the APB slave signals PREADY.
//
// Ports
//   HCLK, HRESETn        shared bus clock, asynchronous active-low reset
//   HSEL .. HREADY       AHB-Lite slave inputs (HSIZE ignored, HTRANS[0] unused)
//   HREADYOUT, HRESP     wait-state / response, decoded from the state register
//   HRDATA               registered read data, held until the next read ends
//   PSEL .. PWDATA       APB3 master outputs (PSEL one-hot, PWDATA = HWDATA)
//   PRDATA .. PSLVERR    APB3 slave responses
// ---------------------------------------------------------------------------
module ahbl_apb_bridge #(
    parameter int NUM_SLAVES = 16,
    parameter int SLV_LSB    = 24,
    parameter int PADDR_W    = 24
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic [PADDR_W-1:0]    PADDR,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] idx_s;
    logic [3:0] idx_r;
    logic       acc_s;
    logic       take_s;
    logic       bad_idx_s;
    logic       apb_active_s;
    logic       unused_s;

    // HSIZE, HTRANS[0] and the address bits outside the index/PADDR fields
    // carry no meaning for this bridge.
    assign unused_s = ^{HSIZE, HTRANS[0], HADDR};

    assign idx_s     = HADDR[SLV_LSB +: 4];
    assign bad_idx_s = ({1'b0, idx_s} >= 5'(NUM_SLAVES));
    assign acc_s     = HSEL & HTRANS[1] & HREADY;
    // A new address is only taken when the previous transfer has finished.
    assign take_s    = acc_s & ((state_r == ST_IDLE) | (state_r == ST_ERR2));

    // Write data is passed straight through: the master holds HWDATA while stalled.
    assign PWDATA = HWDATA;

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (take_s) begin
                    state_nxt_s = bad_idx_s ? ST_ERR1 : ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_nxt_s = PSLVERR ? ST_ERR1 : ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_ERR1: begin
                state_nxt_s = ST_ERR2;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state register only; no input-to-output paths.
    always_comb begin
        HREADYOUT    = 1'b1;
        HRESP        = 1'b0;
        PENABLE      = 1'b0;
        apb_active_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                HREADYOUT = 1'b1;
            end
            ST_SETUP: begin
                HREADYOUT    = 1'b0;
                apb_active_s = 1'b1;
            end
            ST_ACCESS: begin
                HREADYOUT    = 1'b0;
                PENABLE      = 1'b1;
                apb_active_s = 1'b1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    // One-hot PSEL from the latched index; all zero outside SETUP/ACCESS.
    always_comb begin
        PSEL = '0;
        if (apb_active_s) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                PSEL[i] = (idx_r == 4'(i));
            end
        end else begin
            PSEL = '0;
        end
    end

    // Address-phase capture; held stable for the whole APB access.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            idx_r  <= 4'd0;
        end else if (take_s) begin
            PADDR  <= HADDR[PADDR_W-1:0];
            PWRITE <= HWRITE;
            idx_r  <= idx_s;
        end
    end

    // Read data capture on the completing ACCESS cycle, error or not.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HRDATA <= 32'd0;
        end else if ((state_r == ST_ACCESS) && PREADY && !PWRITE) begin
            HRDATA <= PRDATA;
        end
    end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
`timescale 1ns/1ps
module tb_ahbl_apb_bridge;

    logic        HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESETn;
    logic        hsel, hwrite, pready, pslverr, tgt;
    logic [31:0] haddr, hwdata, prdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    wire         hready;

    // Main bridge: 16 slaves
    wire         ro1, rsp1, pen1, pw1;
    wire [31:0]  rd1, pwd1;
    wire [15:0]  psel1;
    wire [23:0]  paddr1;
    // Second bridge: only 2 slaves, for decode-error coverage
    wire         ro2, rsp2, pen2, pw2;
    wire [31:0]  rd2, pwd2;
    wire [1:0]   psel2;
    wire [23:0]  paddr2;

    wire hsel1 = hsel & ~tgt;
    wire hsel2 = hsel & tgt;
    assign hready = tgt ? ro2 : ro1;

    ahbl_apb_bridge #(.NUM_SLAVES(16), .SLV_LSB(24), .PADDR_W(24)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro1), .HRESP(rsp1), .HRDATA(rd1), .PSEL(psel1), .PADDR(paddr1),
        .PENABLE(pen1), .PWRITE(pw1), .PWDATA(pwd1), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr));

    ahbl_apb_bridge #(.NUM_SLAVES(2), .SLV_LSB(24), .PADDR_W(24)) u_dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ro2), .HRESP(rsp2), .HRDATA(rd2), .PSEL(psel2), .PADDR(paddr2),
        .PENABLE(pen2), .PWRITE(pw2), .PWDATA(pwd2), .PRDATA(prdata),
        .PREADY(pready & tgt), .PSLVERR(pslverr));

    // Observe whichever bridge is currently targeted
    wire        o_ro   = tgt ? ro2   : ro1;
    wire        o_rsp  = tgt ? rsp2  : rsp1;
    wire        o_pen  = tgt ? pen2  : pen1;
    wire        o_pw   = tgt ? pw2   : pw1;
    wire [31:0] o_rd   = tgt ? rd2   : rd1;
    wire [31:0] o_pwd  = tgt ? pwd2  : pwd1;
    wire [15:0] o_psel = tgt ? {14'd0, psel2} : psel1;
    wire [23:0] o_paddr = tgt ? paddr2 : paddr1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rd1 = 32'd0;
    logic [31:0] last_rd2 = 32'd0;
    bit          pend_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks for a cycle in which the bridge must be ready (idle or completion)
    task automatic check_done();
        chk("hreadyout_done", 32'(o_ro), 32'd1);
        chk("hresp_done", 32'(o_rsp), 32'(pend_err));
        chk("psel_done", 32'(o_psel), 32'd0);
        chk("penable_done", 32'(o_pen), 32'd0);
        chk("hrdata_done", o_rd, tgt ? last_rd2 : last_rd1);
        pend_err = 1'b0;
    endtask

    task automatic idle_cyc();
        hsel = 1'b1; htrans = 2'b00; pready = 1'b0; pslverr = 1'b0;
        @(negedge HCLK);
        check_done();
        @(posedge HCLK); #1;
    endtask

    // One transfer: address phase in the current cycle, then the data phase.
    // Returns in the completion cycle so the next address can be pipelined.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                        input int nw, input bit se, input logic [31:0] rd);
        int          n_slv;
        int          idx;
        bit          bad;
        logic [15:0] oh;
        int          last_k;
        n_slv = tgt ? 2 : 16;
        idx   = int'(addr[27:24]);
        bad   = (idx >= n_slv);
        oh    = 16'd1 << idx;
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
        hsize = 3'($urandom_range(0, 2)); pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        @(negedge HCLK);
        check_done();
        @(posedge HCLK); #1;
        htrans = 2'b00; hwdata = wd; haddr = $urandom; hwrite = ~wr;
        last_k = bad ? 1 : (se ? 3 + nw : 2 + nw);
        for (int k = 0; k < last_k; k++) begin
            bit acc_cyc;
            bit setup;
            acc_cyc = !bad && (k >= 1) && (k <= 1 + nw);
            setup   = !bad && (k == 0);
            pready  = acc_cyc && (k == 1 + nw);
            pslverr = pready & se;
            prdata  = pready ? rd : $urandom;
            @(negedge HCLK);
            chk("hreadyout_wait", 32'(o_ro), 32'd0);
            chk("hresp_wait", 32'(o_rsp), 32'((k == last_k - 1) && (bad || se)));
            chk("psel", 32'(o_psel), (setup || acc_cyc) ? 32'(oh) : 32'd0);
            chk("penable", 32'(o_pen), 32'(acc_cyc));
            if (setup || acc_cyc) begin
                chk("paddr", 32'(o_paddr), {8'd0, addr[23:0]});
                chk("pwrite", 32'(o_pw), 32'(wr));
                chk("pwdata", o_pwd, wd);
            end
            @(posedge HCLK); #1;
        end
        if (!bad && !wr) begin
            if (tgt) last_rd2 = rd; else last_rd1 = rd;
        end
        pend_err = bad | se;
        pready = 1'b0; pslverr = 1'b0; htrans = 2'b00;
    endtask

    initial begin
        HRESETn = 1'b0; tgt = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = 32'd0;
        hwrite = 1'b0; hwdata = 32'd0; hsize = 3'd2; pready = 1'b0; pslverr = 1'b0;
        prdata = 32'd0;
        #1;
        chk("rst_hreadyout", 32'(ro1), 32'd1);
        chk("rst_hresp", 32'(rsp1), 32'd0);
        chk("rst_hrdata", rd1, 32'd0);
        chk("rst_psel", 32'(psel1), 32'd0);
        chk("rst_penable", 32'(pen1), 32'd0);
        chk("rst_pwrite", 32'(pw1), 32'd0);
        chk("rst_paddr", 32'(paddr1), 32'd0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        idle_cyc();

        // Directed: write, slow read, slave error then normal transfer
        xfer(32'h4100_0010, 1'b1, 32'h5555_5555, 0, 1'b0, 32'd0);
        idle_cyc();
        xfer(32'h4000_0004, 1'b0, 32'd0, 3, 1'b0, 32'hCAFE_F00D);
        idle_cyc();
        xfer(32'h4300_0100, 1'b1, 32'h1234_5678, 1, 1'b1, 32'd0);
        xfer(32'h4500_0040, 1'b0, 32'd0, 0, 1'b0, 32'hA5A5_0001);
        idle_cyc();
        // Back-to-back write then read, then idle-with-HSEL cycles
        xfer(32'h4000_0000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'd0);
        xfer(32'h4100_0000, 1'b0, 32'd0, 0, 1'b0, 32'h0BAD_F00D);
        idle_cyc();
        idle_cyc();

        // Decode error on the 2-slave bridge
        tgt = 1'b1;
        idle_cyc();
        xfer(32'h4F00_0000, 1'b1, 32'h0000_00FF, 0, 1'b0, 32'd0);
        xfer(32'h4100_0008, 1'b0, 32'd0, 1, 1'b0, 32'h7777_1111);
        idle_cyc();
        tgt = 1'b0;
        idle_cyc();

        // Reset in the middle of an ACCESS phase
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4200_0020; hwrite = 1'b1;
        @(negedge HCLK);
        check_done();
        @(posedge HCLK); #1;
        htrans = 2'b00; hwdata = 32'h0F0F_0F0F; pready = 1'b0;
        @(posedge HCLK); #3;
        chk("pre_rst_penable", 32'(pen1), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("arst_psel", 32'(psel1), 32'd0);
        chk("arst_penable", 32'(pen1), 32'd0);
        chk("arst_hreadyout", 32'(ro1), 32'd1);
        chk("arst_hrdata", rd1, 32'd0);
        last_rd1 = 32'd0; last_rd2 = 32'd0; pend_err = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        idle_cyc();
        xfer(32'h4600_0abc, 1'b1, 32'h3C3C_3C3C, 0, 1'b0, 32'd0);
        idle_cyc();

        // Random traffic on the 16-slave bridge
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = {4'h4, 4'($urandom_range(0, 15)), 24'($urandom)};
            xfer(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) idle_cyc();
        end
        idle_cyc();

        // Random traffic on the 2-slave bridge, mixing valid and invalid indices
        tgt = 1'b1;
        idle_cyc();
        for (int n = 0; n < 15; n++) begin
            logic [31:0] a;
            a = {4'h4, 4'($urandom_range(0, 3) == 0 ? $urandom_range(2, 15) : $urandom_range(0, 1)),
                 24'($urandom)};
            xfer(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)),
                 ($urandom_range(0, 5) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) idle_cyc();
        end
        idle_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
